// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-word memory port between the CPU and an
// external requester (boot loader / debug DMA) using req/ack transactions.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin tie-breaking;
// when undefined, the CPU always wins ties.
module mem_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sel;       // 0 = CPU, 1 = EXT
  logic          last_sel;  // side served most recently, 1 = EXT
  logic          lat_we;
  logic          grant_ext_c;

`ifdef MEM_ARB_RR_EN
  // Round-robin: on a tie grant the side that was not served last
  always_comb begin
    grant_ext_c = 1'b0;
    if (cpu_req && ext_req) grant_ext_c = ~last_sel;
    else                    grant_ext_c = ext_req;
  end
`else
  logic unused_last_sel_c;
  assign unused_last_sel_c = last_sel;

  // Fixed priority: CPU wins every tie, EXT only when the CPU is quiet
  always_comb begin
    grant_ext_c = 1'b0;
    grant_ext_c = ext_req & ~cpu_req;
  end
`endif

  // Arbitration FSM: latch winner, sequence the memory access, return data and ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      last_sel  <= 1'b1;
      lat_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      ext_ack   <= 1'b0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ext_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || ext_req) begin
            sel       <= grant_ext_c;
            lat_we    <= grant_ext_c ? ext_we : cpu_we;
            mem_we    <= grant_ext_c ? ext_we : cpu_we;
            mem_addr  <= grant_ext_c ? ext_addr : cpu_addr;
            mem_wdata <= grant_ext_c ? ext_wdata : cpu_wdata;
            cnt       <= (grant_ext_c ? ext_we : cpu_we) ? '0 : CW'(LAT - 1);
            mem_en    <= 1'b1;
            state     <= ACCESS;
          end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!lat_we) begin
            if (sel) ext_rdata <= mem_rdata;
            else     cpu_rdata <= mem_rdata;
          end
          if (sel) ext_ack <= 1'b1;
          else     cpu_ack <= 1'b1;
          last_sel <= sel;
          state    <= IDLE;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized req/ack traffic on both ports against a
// transaction-level reference model; directed cases for single accesses,
// simultaneous requests held from reset, and reset during an access.
module tb_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 3;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ext_req, ext_we, ext_ack;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro model: data appears LAT cycles after the first mem_en of a read
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pd [LAT];
  logic          pv [LAT];
  logic          prev_en;
  logic [DW-1:0] junk;

  always @(posedge clk) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) mem[mem_addr[7:0]] <= mem_wdata;
    pv[0] <= (mem_en === 1'b1) && (mem_we === 1'b0) && !prev_en;
    pd[0] <= mem[mem_addr[7:0]];
    for (int i = 1; i < int'(LAT); i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    prev_en <= (mem_en === 1'b1);
    junk    <= $urandom;
  end

  assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : junk;

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  int            cyc;
  bit            rst_prev;
  bit            act;
  int            t_s, t_n;
  bit            t_ext, t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_rdata;
  logic [DW-1:0] e_cpu_rd, e_ext_rd, e_wdata;
  logic [AW-1:0] e_addr;
  bit            last_ext;
  bit            rand_mode;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Decide the grant the arbiter should make from the inputs it is about to sample
  task automatic model_sample();
    rst_prev = reset;
    if (!reset && !act && (cpu_req || ext_req)) begin
      if (cpu_req && ext_req) begin
`ifdef MEM_ARB_RR_EN
        t_ext = !last_ext;
`else
        t_ext = 1'b0;
`endif
      end else begin
        t_ext = ext_req;
      end
      t_we    = t_ext ? ext_we : cpu_we;
      t_addr  = t_ext ? ext_addr : cpu_addr;
      t_wdata = t_ext ? ext_wdata : cpu_wdata;
      t_n     = t_we ? 1 : int'(LAT);
      t_s     = cyc;
      act     = 1'b1;
      if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
      else      t_rdata = ref_mem[t_addr[7:0]];
    end
  endtask

  // Expected outputs for the current cycle, then compare
  task automatic model_check();
    bit x_en, x_we, x_cack, x_eack;
    x_en = 0; x_we = 0; x_cack = 0; x_eack = 0;
    if (rst_prev) begin
      act      = 1'b0;
      e_cpu_rd = '0;
      e_ext_rd = '0;
      e_addr   = '0;
      e_wdata  = '0;
      last_ext = 1'b1;
    end else if (act) begin
      if (cyc == t_s + 1) begin
        e_addr  = t_addr;
        e_wdata = t_wdata;
      end
      if (cyc >= t_s + 1 && cyc <= t_s + t_n) begin
        x_en = 1'b1;
        x_we = t_we;
      end
      if (cyc == t_s + t_n + 2) begin
        if (t_ext) x_eack = 1'b1;
        else       x_cack = 1'b1;
        if (!t_we) begin
          if (t_ext) e_ext_rd = t_rdata;
          else       e_cpu_rd = t_rdata;
        end
        last_ext = t_ext;
        act      = 1'b0;
      end
    end
    chk("mem_en",    64'(mem_en),    64'(x_en));
    chk("mem_we",    64'(mem_we),    64'(x_we));
    chk("mem_addr",  64'(mem_addr),  64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    chk("cpu_ack",   64'(cpu_ack),   64'(x_cack));
    chk("ext_ack",   64'(ext_ack),   64'(x_eack));
    chk("cpu_rdata", 64'(cpu_rdata), 64'(e_cpu_rd));
    chk("ext_rdata", 64'(ext_rdata), 64'(e_ext_rd));
  endtask

  // Random requester behaviour: hold until ack, sometimes chain, sometimes perturb
  task automatic drive_random();
    bit ca, ea;
    ca = (cpu_ack === 1'b1);
    ea = (ext_ack === 1'b1);
    if (ca) begin
      if ($urandom_range(3) == 0) begin
        cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
      end else cpu_req = 1'b0;
    end else if (!cpu_req && $urandom_range(2) == 0) begin
      cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
    end else if (cpu_req && $urandom_range(7) == 0) begin
      cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
    end
    if (ea) begin
      if ($urandom_range(3) == 0) begin
        ext_we = 1'($urandom); ext_addr = $urandom; ext_wdata = $urandom;
      end else ext_req = 1'b0;
    end else if (!ext_req && $urandom_range(2) == 0) begin
      ext_req = 1'b1; ext_we = 1'($urandom); ext_addr = $urandom; ext_wdata = $urandom;
    end else if (ext_req && $urandom_range(7) == 0) begin
      ext_we = 1'($urandom); ext_addr = $urandom; ext_wdata = $urandom;
    end
    reset = ($urandom_range(199) == 0);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      model_sample();
      @(posedge clk);
      #1;
      cyc++;
      model_check();
      if (rand_mode) drive_random();
    end
  endtask

  task automatic wait_ack(input bit ext_side, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step(1);
      seen = ext_side ? (ext_ack === 1'b1) : (cpu_ack === 1'b1);
    end
    chk(ext_side ? "ext_ack_wait" : "cpu_ack_wait", 64'(seen), 64'd1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; act = 0; rst_prev = 0; last_ext = 1;
    rand_mode = 0;
    e_cpu_rd = '0; e_ext_rd = '0; e_addr = '0; e_wdata = '0;
    prev_en = 0; junk = '0;
    for (int i = 0; i < int'(LAT); i++) begin pv[i] = 0; pd[i] = '0; end
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    reset = 1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    step(3);
    reset = 0;
    step(2);

    // CPU read of 0x10, full LAT read cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    wait_ack(1'b0, 12);
    cpu_req = 0;
    step(2);

    // EXT write 0x20, then CPU reads it back
    ext_req = 1; ext_we = 1; ext_addr = 32'h20; ext_wdata = 32'h12345678;
    wait_ack(1'b1, 12);
    ext_req = 0;
    step(1);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    step(2);
    ext_req = 1; ext_we = 0; ext_addr = 32'h10;
    wait_ack(1'b0, 12);
    cpu_req = 0;
    wait_ack(1'b1, 12);
    ext_req = 0;
    step(2);

    // Both requesters held from reset
    reset = 1;
    step(2);
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
    ext_req = 1; ext_we = 0; ext_addr = 32'h40;
    step(30);
    cpu_req = 0; ext_req = 0;
    step(8);

    // Reset while a write is in its access cycle
    ext_req = 1; ext_we = 1; ext_addr = 32'h55; ext_wdata = 32'hCAFEF00D;
    begin
      bit seen_we;
      seen_we = 1'b0;
      for (int i = 0; i < 8 && !seen_we; i++) begin
        step(1);
        seen_we = (mem_we === 1'b1);
      end
      chk("we_wait", 64'(seen_we), 64'd1);
    end
    reset = 1;
    ext_req = 0;
    step(1);
    reset = 0;
    step(4);

    // Randomized traffic with occasional resets
    rand_mode = 1;
    step(3000);
    rand_mode = 0;
    reset = 0; cpu_req = 0; ext_req = 0;
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
